// File: rtl/tile_sequencer.sv
// tile_sequencer: splits an M x K x N matrix job into systolic-array tiles and
// issues one packed command per tile to the command queue. It tracks how many
// issued tiles are still in flight so that K-accumulating tiles wait for their
// partial sums, and it signals job completion once everything has drained.
// Optional feature: define TILE_SEQ_KACC_EN to tile along K and accumulate
// into D. Without it, one K tile of min(W,K) is issued and C always comes
// from the bias region.
// ADDR_WIDTH must satisfy 24 + 4*ADDR_WIDTH <= 64 so that the command fits.
module tile_sequencer #(
    parameter int ADDR_WIDTH           = 10,
    parameter int SYSTOLIC_ARRAY_WIDTH = 16,
    parameter int DIM_WIDTH            = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [DIM_WIDTH-1:0]  job_m,
    input  logic [DIM_WIDTH-1:0]  job_k,
    input  logic [DIM_WIDTH-1:0]  job_n,
    input  logic [ADDR_WIDTH-1:0] job_base_a,
    input  logic [ADDR_WIDTH-1:0] job_base_b,
    input  logic [ADDR_WIDTH-1:0] job_base_c,
    input  logic [ADDR_WIDTH-1:0] job_base_d,
    output logic                  cmd_valid,
    output logic [63:0]           cmd_data,
    input  logic                  cmd_ready,
    input  logic                  tile_done,
    output logic                  job_busy,
    output logic                  job_done
);
    localparam int W     = SYSTOLIC_ARRAY_WIDTH;
    localparam int LOG_W = $clog2(W);
    localparam int PW    = 2 * DIM_WIDTH + LOG_W;
    localparam logic [DIM_WIDTH:0]   W_M1  = (DIM_WIDTH + 1)'(W - 1);
    localparam logic [DIM_WIDTH-1:0] W_D   = DIM_WIDTH'(W);
    localparam logic [DIM_WIDTH-1:0] ONE_D = DIM_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DEP, DRAIN} state_t;

    state_t                 state_reg, state_next;
    logic [DIM_WIDTH-1:0]   dim_reg [3];
    logic [DIM_WIDTH-1:0]   mt_reg, kt_reg, nt_reg;
    logic [DIM_WIDTH-1:0]   mi_reg, ki_reg, ni_reg;
    logic [ADDR_WIDTH-1:0]  base_a_reg, base_b_reg, base_c_reg, base_d_reg;
    logic [7:0]             outstanding_reg;

    logic                   job_accept, job_empty, cmd_hs, tile_done_eff;
    logic                   m_last, k_last, n_last;
    logic [DIM_WIDTH-1:0]   tile_idx [3];
    logic [7:0]             tile_len [3];
    logic [PW-1:0]          a_tile, b_tile, cd_tile;
    logic [ADDR_WIDTH-1:0]  addr_a, addr_b, addr_c, addr_d;
    logic [63:0]            cmd_packed;

    // Number of W-wide tiles needed to cover a dimension (ceiling division).
    function automatic logic [DIM_WIDTH-1:0] ceil_tiles(input logic [DIM_WIDTH-1:0] x);
        logic [DIM_WIDTH:0] s;
        s = {1'b0, x} + W_M1;
        return DIM_WIDTH'(s >> LOG_W);
    endfunction

    assign job_accept    = (state_reg == IDLE) && job_valid;
    assign job_empty     = (job_m == '0) || (job_k == '0) || (job_n == '0);
    assign cmd_hs        = cmd_valid && cmd_ready;
    // A completion with nothing outstanding is spurious and must not underflow.
    assign tile_done_eff = tile_done && (outstanding_reg != 8'd0);

    assign m_last = (mi_reg == mt_reg - ONE_D);
    assign k_last = (ki_reg == kt_reg - ONE_D);
    assign n_last = (ni_reg == nt_reg - ONE_D);

    assign tile_idx[0] = mi_reg;
    assign tile_idx[1] = ki_reg;
    assign tile_idx[2] = ni_reg;

    // Edge tiles are clipped to whatever remains of each dimension.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_len
            logic [DIM_WIDTH-1:0] rem;
            assign rem          = dim_reg[gi] - (tile_idx[gi] << LOG_W);
            assign tile_len[gi] = 8'((rem > W_D) ? W_D : rem);
        end
    endgenerate

    // Tile offsets in units of W; sums wrap naturally at ADDR_WIDTH bits.
    assign a_tile  = PW'(mi_reg) * PW'(kt_reg) + PW'(ki_reg);
    assign b_tile  = PW'(ki_reg) * PW'(nt_reg) + PW'(ni_reg);
    assign cd_tile = PW'(mi_reg) * PW'(nt_reg) + PW'(ni_reg);
    assign addr_a  = base_a_reg + ADDR_WIDTH'(a_tile << LOG_W);
    assign addr_b  = base_b_reg + ADDR_WIDTH'(b_tile << LOG_W);
    assign addr_d  = base_d_reg + ADDR_WIDTH'(cd_tile << LOG_W);
`ifdef TILE_SEQ_KACC_EN
    // Later K slices accumulate onto the partial result already in D.
    assign addr_c  = (ki_reg == '0) ? (base_c_reg + ADDR_WIDTH'(cd_tile << LOG_W)) : addr_d;
`else
    assign addr_c  = base_c_reg + ADDR_WIDTH'(cd_tile << LOG_W);
`endif

    // Pack the command fields LSB-first; unused upper bits stay zero.
    always_comb begin
        cmd_packed                                 = '0;
        cmd_packed[7:0]                            = tile_len[0];
        cmd_packed[15:8]                           = tile_len[1];
        cmd_packed[23:16]                          = tile_len[2];
        cmd_packed[24 +: ADDR_WIDTH]               = addr_a;
        cmd_packed[24 + ADDR_WIDTH +: ADDR_WIDTH]  = addr_b;
        cmd_packed[24 + 2*ADDR_WIDTH +: ADDR_WIDTH] = addr_c;
        cmd_packed[24 + 3*ADDR_WIDTH +: ADDR_WIDTH] = addr_d;
    end

    // Next-state and handshake outputs; cmd_data reads zero whenever no command is offered.
    always_comb begin
        state_next = state_reg;
        job_ready  = (state_reg == IDLE);
        job_busy   = (state_reg != IDLE);
        cmd_valid  = (state_reg == ISSUE);
        job_done   = (state_reg == DRAIN) && (outstanding_reg == 8'd0);
        cmd_data   = cmd_valid ? cmd_packed : 64'd0;
        case (state_reg)
            IDLE: begin
                if (job_valid) state_next = job_empty ? DRAIN : ISSUE;
            end
            ISSUE: begin
                if (cmd_ready) begin
                    if (m_last && n_last && k_last) state_next = DRAIN;
                    else if (!k_last)               state_next = WAIT_DEP;
                end
            end
            WAIT_DEP: begin
                if (outstanding_reg == 8'd0) state_next = ISSUE;
            end
            DRAIN: begin
                if (outstanding_reg == 8'd0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State, job latch, tile walk (mi outer, ni middle, ki inner) and in-flight count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            outstanding_reg <= 8'd0;
            mi_reg          <= '0;
            ki_reg          <= '0;
            ni_reg          <= '0;
        end else begin
            state_reg <= state_next;
            if (cmd_hs && !tile_done_eff)      outstanding_reg <= outstanding_reg + 8'd1;
            else if (tile_done_eff && !cmd_hs) outstanding_reg <= outstanding_reg - 8'd1;
            if (job_accept) begin
                dim_reg[0] <= job_m;
                dim_reg[1] <= job_k;
                dim_reg[2] <= job_n;
                base_a_reg <= job_base_a;
                base_b_reg <= job_base_b;
                base_c_reg <= job_base_c;
                base_d_reg <= job_base_d;
                mt_reg     <= ceil_tiles(job_m);
                nt_reg     <= ceil_tiles(job_n);
`ifdef TILE_SEQ_KACC_EN
                kt_reg     <= ceil_tiles(job_k);
`else
                kt_reg     <= ONE_D;
`endif
                mi_reg     <= '0;
                ki_reg     <= '0;
                ni_reg     <= '0;
            end else if (cmd_hs) begin
                if (k_last) begin
                    ki_reg <= '0;
                    if (n_last) begin
                        ni_reg <= '0;
                        mi_reg <= mi_reg + ONE_D;
                    end else begin
                        ni_reg <= ni_reg + ONE_D;
                    end
                end else begin
                    ki_reg <= ki_reg + ONE_D;
                end
            end
        end
    end
endmodule

// File: doc/tile_sequencer.md
TILE_SEQUENCER -- requirements
Module: tile_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10: scratchpad address width, matching the command-queue consumer; legal only while 24+4*ADDR_WIDTH <= 64.
REQ-002 SHALL have parameter SYSTOLIC_ARRAY_WIDTH, default 16 (W): tile edge in rows and columns; power of two.
REQ-003 SHALL have parameter DIM_WIDTH, default 12: width of the job dimension fields.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have ports job_valid (input, 1) and job_ready (output, 1): job handshake; a transfer occurs when both are high.
REQ-007 SHALL have ports job_m, job_k and job_n: inputs, DIM_WIDTH each; matrix dimensions M, K and N.
REQ-008 SHALL have ports job_base_a, job_base_b, job_base_c and job_base_d: inputs, ADDR_WIDTH each; base addresses of the A, B, bias C and result D regions.
REQ-009 SHALL have ports cmd_valid (output, 1), cmd_data (output, 64) and cmd_ready (input, 1): tile-command handshake to the command queue.
REQ-010 SHALL have port tile_done, input, 1: one-cycle pulse marking completion of one issued tile command.
REQ-011 SHALL have ports job_busy (output, 1) and job_done (output, 1): job_busy is high while a job is held; job_done is a one-cycle completion pulse.

Function
REQ-012 SHALL pack cmd_data LSB-first with these fields, and zero the remaining upper bits:
  - len_m[7:0], len_k[15:8], len_n[23:16]
  - addr_a, addr_b, addr_c, addr_d, each ADDR_WIDTH bits, starting at bit 24.
REQ-013 SHALL use tile counts MT=ceil(M/W), KT=ceil(K/W), NT=ceil(N/W), and iterate mi outer, ni middle, ki inner.
REQ-014 SHALL compute, per tile:
  - len_m = min(W, M-mi*W); len_k and len_n likewise.
  - addr_a = base_a+(mi*KT+ki)*W; addr_b = base_b+(ki*NT+ni)*W.
  - addr_d = base_d+(mi*NT+ni)*W.
  - addr_c = base_c+(mi*NT+ni)*W when ki==0, else addr_c = addr_d.
  - All address sums wrap modulo 2^ADDR_WIDTH.
REQ-015 SHALL implement states IDLE, ISSUE, WAIT_DEP and DRAIN.
REQ-016 SHALL drive job_ready high only in IDLE; an accepted job latches all job inputs, and the first cmd_valid rises on the next cycle.
REQ-017 SHALL hold cmd_valid and cmd_data stable from assertion until the cycle cmd_ready is high; the tile indices advance only on that handshake.
REQ-018 SHALL keep an outstanding counter (8 bits): +1 on command handshake, -1 on tile_done, unchanged when both occur in the same cycle.
REQ-019 SHALL enter WAIT_DEP and hold cmd_valid low before any tile with ki>0 while outstanding != 0, and resume ISSUE when outstanding == 0.
REQ-020 SHALL enter DRAIN after the last tile handshake; when outstanding == 0, pulse job_done for one cycle and return to IDLE.
REQ-021 SHALL treat a job with M, K or N equal to 0 as follows: issue no commands, pulse job_done the cycle after acceptance, return to IDLE.
REQ-022 SHALL ignore tile_done while outstanding == 0: the counter does not underflow.
REQ-023 SHALL drive job_busy = (state != IDLE).

Reset
REQ-024 SHALL, on rst, on the next clock edge regardless of state:
  - clear state to IDLE, the outstanding counter and all tile indices;
  - drive cmd_valid=0, cmd_data=0, job_done=0, job_busy=0, job_ready=1;
  - discard any in-flight job without a job_done pulse.

Configuration
REQ-025 SHALL, with TILE_SEQ_KACC_EN defined, perform K tiling per REQ-013, REQ-014 and REQ-019.
REQ-026 SHALL, without TILE_SEQ_KACC_EN, force KT=1, len_k=min(W,K) and addr_c=base_c+(mi*NT+ni)*W; WAIT_DEP is then never entered, and K beyond W is ignored.

Verification
REQ-027 SHALL cover: M=40, K=16, N=16, bases A=0/B=100/C=200/D=300, cmd_ready=1 -> three commands:
  - len_m 16, 16, 8;
  - addr_a 0, 16, 32; addr_b 100 each; addr_c 200, 216, 232; addr_d 300, 316, 332;
  - job_done one cycle after the third tile_done.
REQ-028 SHALL cover, with TILE_SEQ_KACC_EN: M=16, K=32, N=16, same bases:
  - cmd0 has addr_a=0, addr_b=100, addr_c=200, addr_d=300;
  - no cmd_valid until tile_done;
  - cmd1 has addr_a=16, addr_b=116, addr_c=300, addr_d=300.
REQ-029 SHALL cover cmd_ready held low 5 cycles on the first command -> cmd_data unchanged throughout, and no index advance.
REQ-030 SHALL cover job_n=0 -> zero commands and job_done at acceptance+1.
REQ-031 SHALL cover a command handshake and tile_done in the same cycle with outstanding=1 -> outstanding stays 1.
REQ-032 SHALL cover rst asserted mid-ISSUE -> next cycle cmd_valid=0, job_ready=1, and no job_done.
